// File: rtl/fpdlink_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : fpdlink_pkg                                                    |
// | Purpose    : Shared types and constants for the FPD-Link phase detector:   |
// |              FSM state encoding, vote accumulator width and recalibration  |
// |              timer width.                                                  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package fpdlink_pkg;

  // Signed vote accumulator width.
  localparam int ACC_W = 8;

  // Periodic recalibration timer width (holds up to CAL_INTERVAL-1).
  localparam int TIMER_W = 24;

  typedef enum logic [2:0] {
    INIT_CAL  = 3'd0,
    INIT_WAIT = 3'd1,
    INIT_RST  = 3'd2,
    RST_WAIT  = 3'd3,
    TRACK     = 3'd4,
    STEP_WAIT = 3'd5,
    PCAL_WAIT = 3'd6
  } fpd_state_t;

  // True for the states that wait out the guard window and then busy.
  function automatic logic is_wait_state(input fpd_state_t s);
    return (s == INIT_WAIT) || (s == RST_WAIT) ||
           (s == STEP_WAIT) || (s == PCAL_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpdlink_pd_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : fpdlink_pd_accum                                              |
// | Purpose    : Signed up/down vote accumulator for the ISERDES phase         |
// |              detector. Flags the vote that brings the total to             |
// |              +/-PD_THRESH and clears itself on that same edge, so the      |
// |              stored value never reaches or crosses the threshold.         |
// | Ports      : gclk, rst_n     clock / async active-low reset               |
// |              valid, incdec   phase-detector vote and direction            |
// |              clr             synchronous clear (outside TRACK)            |
// |              en              vote enable (TRACK only)                     |
// |              hit_inc/hit_dec threshold reached this cycle (comb)          |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module fpdlink_pd_accum
  import fpdlink_pkg::*;
#(
  parameter int PD_THRESH = 8
) (
  input  logic gclk,
  input  logic rst_n,
  input  logic valid,
  input  logic incdec,
  input  logic clr,
  input  logic en,
  output logic hit_inc,
  output logic hit_dec
);

  localparam logic signed [ACC_W-1:0] THRESH_POS = ACC_W'(PD_THRESH);
  localparam logic signed [ACC_W-1:0] THRESH_NEG = -THRESH_POS;
  localparam logic signed [ACC_W-1:0] ACC_ONE    = ACC_W'(1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic                    vote;

  always_comb begin
    vote    = en && valid;
    acc_nxt = acc;
    if (vote) begin
      acc_nxt = incdec ? (acc + ACC_ONE) : (acc - ACC_ONE);
    end
    hit_inc = vote &&  incdec && (acc_nxt == THRESH_POS);
    hit_dec = vote && !incdec && (acc_nxt == THRESH_NEG);
  end

  // Clearing on the hit edge means a stored value of +/-PD_THRESH never
  // exists, which also rules out any wrap-around of the 8-bit register.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr || hit_inc || hit_dec) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpdlink_phase_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : fpdlink_phase_detector                                        |
// | Purpose    : Init / tracking controller for an FPD-Link IODELAY pair.      |
// |              Runs calibrate -> reset of the delay elements, then steps     |
// |              the delay from phase-detector votes. Optional periodic slave  |
// |              recalibration is compiled in with the macro                   |
// |              FPDLINK_PD_PERIODIC_CAL_EN.                                   |
// | Ports      : gclk     fabric clock                                         |
// |              rst_n    async active-low reset                               |
// |              busy     slave IODELAY busy                                   |
// |              valid    phase-detector result valid                          |
// |              incdec   phase-detector direction (1 = increment)             |
// |              cal_m    master calibrate pulse                               |
// |              cal_s    slave calibrate pulse                                |
// |              iod_rst  IODELAY reset pulse                                  |
// |              inc      step direction, only meaningful with ce              |
// |              ce       IODELAY step enable pulse                            |
// |              locked   high in TRACK / STEP_WAIT / PCAL_WAIT                |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module fpdlink_phase_detector
  import fpdlink_pkg::*;
#(
  parameter int PD_THRESH    = 8,
  parameter int CAL_INTERVAL = 65536,
  parameter int GUARD_CYCLES = 2
) (
  input  logic gclk,
  input  logic rst_n,
  input  logic busy,
  input  logic valid,
  input  logic incdec,
  output logic cal_m,
  output logic cal_s,
  output logic iod_rst,
  output logic inc,
  output logic ce,
  output logic locked
);

  localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(GUARD_CYCLES);

  fpd_state_t         state;
  logic [GUARD_W-1:0] guard;
  logic [1:0]         rst_sync;
  logic               rst_done;
  logic               wait_done;
  logic               acc_en;
  logic               acc_clr;
  logic               hit_inc;
  logic               hit_dec;
  logic               step_due;
  logic               cal_due;

  // Two-flop release synchroniser; assertion stays asynchronous.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end
  assign rst_done = rst_sync[1];

  assign acc_en    = (state == TRACK);
  assign acc_clr   = !acc_en;
  assign step_due  = hit_inc || hit_dec;
  assign wait_done = (guard == '0) && !busy;

  fpdlink_pd_accum #(
    .PD_THRESH (PD_THRESH)
  ) u_accum (
    .gclk    (gclk),
    .rst_n   (rst_n),
    .valid   (valid),
    .incdec  (incdec),
    .clr     (acc_clr),
    .en      (acc_en),
    .hit_inc (hit_inc),
    .hit_dec (hit_dec)
  );

`ifdef FPDLINK_PD_PERIODIC_CAL_EN
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CAL_INTERVAL - 1);

  logic [TIMER_W-1:0] timer;

  // Expiry is the CAL_INTERVAL-th TRACK cycle. If a step claims that cycle
  // the timer parks at its last value so recalibration fires on the next
  // TRACK cycle.
  assign cal_due = (state == TRACK) && (timer == TIMER_LAST);

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state == TRACK) begin
      if (timer != TIMER_LAST) begin
        timer <= timer + 1'b1;
      end else if (!step_due) begin
        timer <= '0;
      end
    end
  end
`else
  assign cal_due = 1'b0;
`endif

  // Outputs are registered together with the state, so every pulse lands in
  // the first cycle of the wait state that follows the issuing state.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT_CAL;
      guard   <= '0;
      cal_m   <= 1'b0;
      cal_s   <= 1'b0;
      iod_rst <= 1'b0;
      inc     <= 1'b0;
      ce      <= 1'b0;
      locked  <= 1'b0;
    end else begin
      cal_m   <= 1'b0;
      cal_s   <= 1'b0;
      iod_rst <= 1'b0;
      inc     <= 1'b0;
      ce      <= 1'b0;

      if (is_wait_state(state) && (guard != '0)) begin
        guard <= guard - 1'b1;
      end

      case (state)
        INIT_CAL: begin
          if (rst_done) begin
            cal_m <= 1'b1;
            cal_s <= 1'b1;
            guard <= GUARD_INIT;
            state <= INIT_WAIT;
          end
        end

        INIT_WAIT: begin
          if (wait_done) begin
            state <= INIT_RST;
          end
        end

        INIT_RST: begin
          iod_rst <= 1'b1;
          guard   <= GUARD_INIT;
          state   <= RST_WAIT;
        end

        RST_WAIT: begin
          if (wait_done) begin
            locked <= 1'b1;
            state  <= TRACK;
          end
        end

        TRACK: begin
          // A due step always takes priority over a due recalibration.
          if (step_due) begin
            ce    <= 1'b1;
            inc   <= hit_inc;
            guard <= GUARD_INIT;
            state <= STEP_WAIT;
          end else if (cal_due) begin
            cal_s <= 1'b1;
            guard <= GUARD_INIT;
            state <= PCAL_WAIT;
          end
        end

        STEP_WAIT: begin
          if (wait_done) begin
            state <= TRACK;
          end
        end

`ifdef FPDLINK_PD_PERIODIC_CAL_EN
        PCAL_WAIT: begin
          if (wait_done) begin
            state <= TRACK;
          end
        end
`endif

        default: begin
          locked <= 1'b0;
          state  <= INIT_CAL;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpdlink_phase_detector.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_fpdlink_phase_detector                                     |
// | Purpose    : Directed self-checking bench for fpdlink_phase_detector.      |
// |              Output vector checked as {cal_m,cal_s,iod_rst,ce,inc,locked}. |
// |              Periodic-cal scenarios follow FPDLINK_PD_PERIODIC_CAL_EN.     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_fpdlink_phase_detector;

  localparam int PD_THRESH    = 8;
  localparam int CAL_INTERVAL = 16;
  localparam int GUARD_CYCLES = 2;

  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_CAL   = 6'b110000;
  localparam logic [5:0] O_RST   = 6'b001000;
  localparam logic [5:0] O_LOCK  = 6'b000001;
  localparam logic [5:0] O_STEPI = 6'b000111;
  localparam logic [5:0] O_STEPD = 6'b000101;
  localparam logic [5:0] O_PCAL  = 6'b010001;

  logic gclk   = 1'b0;
  logic rst_n  = 1'b1;
  logic busy   = 1'b0;
  logic valid  = 1'b0;
  logic incdec = 1'b0;
  logic cal_m, cal_s, iod_rst, inc, ce, locked;
  logic [5:0] outs;

  int checks   = 0;
  int errors   = 0;
  int busy_cnt = 0;

  assign outs = {cal_m, cal_s, iod_rst, ce, inc, locked};

  fpdlink_phase_detector #(
    .PD_THRESH    (PD_THRESH),
    .CAL_INTERVAL (CAL_INTERVAL),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) dut (
    .gclk    (gclk),
    .rst_n   (rst_n),
    .busy    (busy),
    .valid   (valid),
    .incdec  (incdec),
    .cal_m   (cal_m),
    .cal_s   (cal_s),
    .iod_rst (iod_rst),
    .inc     (inc),
    .ce      (ce),
    .locked  (locked)
  );

  always #5 gclk = ~gclk;

  // Slave model: busy for 5 rising edges after any calibrate or reset pulse.
  always @(negedge gclk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      busy     = 1'b0;
    end else if (cal_m || cal_s || iod_rst) begin
      busy_cnt = 5;
      busy     = 1'b1;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      busy = (busy_cnt != 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge gclk);
  endtask

  // One vote sampled on the next rising edge, outputs checked just after it.
  task automatic vote(input logic dir, input logic [5:0] exp, input string tag);
    valid  = 1'b1;
    incdec = dir;
    tick();
    valid  = 1'b0;
    incdec = 1'b0;
    check(tag, outs, exp);
  endtask

  // Init sequence from reset release: cal pulse, iod_rst 7 cycles later,
  // locked 6 cycles after that (busy model holds busy 5 edges each time).
  task automatic run_init(input string tag);
    int n;
    n = 0;
    while (!cal_m && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_cal_pulse"}, outs, O_CAL);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check({tag, "_to_iod_rst"}, outs, (i == 7) ? O_RST : O_IDLE);
    end
    for (int i = 1; i <= 6; i++) begin
      tick();
      check({tag, "_to_locked"}, outs, (i == 6) ? O_LOCK : O_IDLE);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_cal;
    int n_ce;

    #2 rst_n = 1'b0;
    tick();
    check("reset_outs", outs, O_IDLE);
    tick();
    check("reset_outs_hold", outs, O_IDLE);
    rst_n = 1'b1;
    run_init("init");

`ifdef FPDLINK_PD_PERIODIC_CAL_EN
    // Step and timer expiry coincide on the 16th TRACK cycle.
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("pre_vote_idle", outs, O_LOCK);
    end
    for (int i = 1; i <= 8; i++) begin
      vote(1'b1, (i == 8) ? O_STEPI : O_LOCK, "coincide_vote");
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("coincide_step_wait", outs, O_LOCK);
    end
    tick();
    check("coincide_cal_s", outs, O_PCAL);
    tick();
    check("coincide_cal_s_end", outs, O_LOCK);
    // Wait out PCAL_WAIT (busy model) before the next scenario.
    repeat (8) tick();
`else
    // Eight increments: step pulse right after the 8th vote.
    for (int i = 1; i <= 8; i++) begin
      vote(1'b1, (i == 8) ? O_STEPI : O_LOCK, "inc_vote");
    end
    check("inc_acc_clear", dut.u_accum.acc, 0);
    // Votes during STEP_WAIT must be ignored.
    for (int i = 1; i <= 3; i++) begin
      vote(1'b1, O_LOCK, "stepwait_vote");
    end
    check("stepwait_acc_zero", dut.u_accum.acc, 0);

    // Mixed: +5, -3, then -10 -> decrement step on the 10th.
    for (int i = 1; i <= 5; i++) vote(1'b1, O_LOCK, "mix_plus");
    for (int i = 1; i <= 3; i++) vote(1'b0, O_LOCK, "mix_minus");
    check("mix_acc_net2", dut.u_accum.acc, 2);
    for (int i = 1; i <= 10; i++) begin
      vote(1'b0, (i == 10) ? O_STEPD : O_LOCK, "mix_dec_vote");
    end
    check("mix_acc_clear", dut.u_accum.acc, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("mix_step_wait", outs, O_LOCK);
    end

    // No periodic recalibration without the macro.
    n_cal = 0;
    n_ce  = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (cal_s) n_cal++;
      if (ce)    n_ce++;
    end
    check("no_periodic_cal_s", n_cal, 0);
    check("no_spurious_ce", n_ce, 0);
    check("still_locked", outs, O_LOCK);
`endif

    // Reset in the middle of STEP_WAIT.
    for (int i = 1; i <= 8; i++) begin
      vote(1'b1, (i == 8) ? O_STEPI : O_LOCK, "pre_rst_vote");
    end
    tick();
    check("pre_rst_step_wait", outs, O_LOCK);
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", outs, O_IDLE);
    tick();
    check("rst_hold_outs", outs, O_IDLE);
    check("rst_acc_zero", dut.u_accum.acc, 0);
    rst_n = 1'b1;
    run_init("reinit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
